// File: rtl/ahb_id_arbiter.sv
// Shares one AHB-Lite master port between the CPU instruction (I) and data (D) ports.
// D has fixed priority; I wins after D_STREAK back-to-back D grants while it waits.
module ahb_id_arbiter #(
    parameter int D_STREAK = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,

    input  logic [31:0] HADDR_I,
    input  logic [1:0]  HTRANS_I,
    input  logic        HWRITE_I,
    input  logic [2:0]  HSIZE_I,
    input  logic [31:0] HWDATA_I,
    output logic [31:0] HRDATA_I,
    output logic        HREADY_I,
    output logic        HRESP_I,

    input  logic [31:0] HADDR_D,
    input  logic [1:0]  HTRANS_D,
    input  logic        HWRITE_D,
    input  logic [2:0]  HSIZE_D,
    input  logic [31:0] HWDATA_D,
    output logic [31:0] HRDATA_D,
    output logic        HREADY_D,
    output logic        HRESP_D,

    output logic [31:0] HADDR_M,
    output logic [1:0]  HTRANS_M,
    output logic        HWRITE_M,
    output logic [2:0]  HSIZE_M,
    output logic [2:0]  HBURST_M,
    output logic [31:0] HWDATA_M,
    input  logic [31:0] HRDATA_M,
    input  logic        HREADY_M,
    input  logic        HRESP_M
);

    localparam int SW = (D_STREAK < 1) ? 1 : $clog2(D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(D_STREAK);
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_I    = 2'b01,
        OWN_D    = 2'b10
    } owner_e;

    owner_e          dp_owner;
    owner_e          dp_owner_nxt;
    logic [SW-1:0]   streak;
    logic [SW-1:0]   streak_nxt;

    logic            pend_i_vld;
    logic [31:0]     pend_i_addr;
    logic            pend_i_write;
    logic [2:0]      pend_i_size;
    logic            pend_d_vld;
    logic [31:0]     pend_d_addr;
    logic            pend_d_write;
    logic [2:0]      pend_d_size;

    logic [31:0]     addr_q;
    logic            write_q;
    logic [2:0]      size_q;

    logic            outstanding_i;
    logic            outstanding_d;
    logic            ready_i;
    logic            ready_d;
    logic            live_i;
    logic            live_d;
    logic            cand_i;
    logic            cand_d;
    logic            slot;
    logic            i_first;
    logic            grant_i;
    logic            grant_d;
    logic [31:0]     sel_addr;
    logic            sel_write;
    logic [2:0]      sel_size;

    // Only HTRANS[1] matters: SEQ and NONSEQ are both reissued downstream as NONSEQ.
    logic            unused_trans_lsb;
    assign unused_trans_lsb = HTRANS_I[0] ^ HTRANS_D[0];

    assign outstanding_i = pend_i_vld || (dp_owner == OWN_I);
    assign outstanding_d = pend_d_vld || (dp_owner == OWN_D);

    assign ready_i = !HRESETn || !outstanding_i || ((dp_owner == OWN_I) && HREADY_M);
    assign ready_d = !HRESETn || !outstanding_d || ((dp_owner == OWN_D) && HREADY_M);

    assign live_i = HRESETn && HTRANS_I[1] && ready_i;
    assign live_d = HRESETn && HTRANS_D[1] && ready_d;

    assign cand_i = pend_i_vld || live_i;
    assign cand_d = pend_d_vld || live_d;

    assign slot    = HRESETn && HREADY_M;
    assign i_first = cand_i && (!cand_d || (streak == STREAK_MAX));
    assign grant_i = slot && i_first;
    assign grant_d = slot && cand_d && !i_first;

    // Idle cycles keep the last issued address phase on the bus.
    always_comb begin
        sel_addr  = addr_q;
        sel_write = write_q;
        sel_size  = size_q;
        if (grant_d) begin
            sel_addr  = pend_d_vld ? pend_d_addr  : HADDR_D;
            sel_write = pend_d_vld ? pend_d_write : HWRITE_D;
            sel_size  = pend_d_vld ? pend_d_size  : HSIZE_D;
        end else if (grant_i) begin
            sel_addr  = pend_i_vld ? pend_i_addr  : HADDR_I;
            sel_write = pend_i_vld ? pend_i_write : HWRITE_I;
            sel_size  = pend_i_vld ? pend_i_size  : HSIZE_I;
        end
    end

    always_comb begin
        dp_owner_nxt = dp_owner;
        streak_nxt   = streak;
        if (slot) begin
            if (grant_d) begin
                dp_owner_nxt = OWN_D;
            end else if (grant_i) begin
                dp_owner_nxt = OWN_I;
            end else begin
                dp_owner_nxt = OWN_NONE;
            end
        end
        if (grant_i) begin
            streak_nxt = '0;
        end else if (grant_d && cand_i && (streak != STREAK_MAX)) begin
            streak_nxt = streak + 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dp_owner <= OWN_NONE;
            streak   <= '0;
        end else begin
            dp_owner <= dp_owner_nxt;
            streak   <= streak_nxt;
        end
    end

    // A live request that is not issued this cycle is parked; it cannot collide
    // with an existing pend because HREADY_x is low while one is held.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            pend_i_vld   <= 1'b0;
            pend_i_addr  <= '0;
            pend_i_write <= 1'b0;
            pend_i_size  <= '0;
            pend_d_vld   <= 1'b0;
            pend_d_addr  <= '0;
            pend_d_write <= 1'b0;
            pend_d_size  <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            size_q       <= '0;
        end else begin
            if (grant_i || grant_d) begin
                addr_q  <= sel_addr;
                write_q <= sel_write;
                size_q  <= sel_size;
            end
            if (grant_i) begin
                pend_i_vld <= 1'b0;
            end else if (live_i) begin
                pend_i_vld   <= 1'b1;
                pend_i_addr  <= HADDR_I;
                pend_i_write <= HWRITE_I;
                pend_i_size  <= HSIZE_I;
            end
            if (grant_d) begin
                pend_d_vld <= 1'b0;
            end else if (live_d) begin
                pend_d_vld   <= 1'b1;
                pend_d_addr  <= HADDR_D;
                pend_d_write <= HWRITE_D;
                pend_d_size  <= HSIZE_D;
            end
        end
    end

    assign HTRANS_M = (grant_i || grant_d) ? TRANS_NONSEQ : TRANS_IDLE;
    assign HADDR_M  = sel_addr;
    assign HWRITE_M = sel_write;
    assign HSIZE_M  = sel_size;
    assign HBURST_M = 3'b000;
    assign HWDATA_M = (dp_owner == OWN_D) ? HWDATA_D : HWDATA_I;

    assign HREADY_I = ready_i;
    assign HREADY_D = ready_d;
    assign HRESP_I  = HRESETn && (dp_owner == OWN_I) && HRESP_M;
    assign HRESP_D  = HRESETn && (dp_owner == OWN_D) && HRESP_M;
    assign HRDATA_I = HRDATA_M;
    assign HRDATA_D = HRDATA_M;

endmodule

// File: tb/tb_ahb_id_arbiter.sv
// Directed bench for ahb_id_arbiter: literal expectations per scenario plus a
// transaction-level reference checked against every output on every cycle.
module tb_ahb_id_arbiter;

    localparam int DS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] haddr_i, haddr_d, hwdata_i, hwdata_d;
    logic [1:0]  htrans_i, htrans_d;
    logic        hwrite_i, hwrite_d;
    logic [2:0]  hsize_i, hsize_d;
    logic [31:0] hrdata_i, hrdata_d;
    logic        hready_i, hready_d, hresp_i, hresp_d;
    logic [31:0] haddr_m, hwdata_m, hrdata_m;
    logic [1:0]  htrans_m;
    logic        hwrite_m, hready_m, hresp_m;
    logic [2:0]  hsize_m, hburst_m;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ahb_id_arbiter #(.D_STREAK(DS)) dut (
        .HCLK(clk), .HRESETn(rst_n),
        .HADDR_I(haddr_i), .HTRANS_I(htrans_i), .HWRITE_I(hwrite_i), .HSIZE_I(hsize_i),
        .HWDATA_I(hwdata_i), .HRDATA_I(hrdata_i), .HREADY_I(hready_i), .HRESP_I(hresp_i),
        .HADDR_D(haddr_d), .HTRANS_D(htrans_d), .HWRITE_D(hwrite_d), .HSIZE_D(hsize_d),
        .HWDATA_D(hwdata_d), .HRDATA_D(hrdata_d), .HREADY_D(hready_d), .HRESP_D(hresp_d),
        .HADDR_M(haddr_m), .HTRANS_M(htrans_m), .HWRITE_M(hwrite_m), .HSIZE_M(hsize_m),
        .HBURST_M(hburst_m), .HWDATA_M(hwdata_m), .HRDATA_M(hrdata_m),
        .HREADY_M(hready_m), .HRESP_M(hresp_m)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: each master owns a parked request slot; the bus tracks who owns the
    // data phase and how many times I has been passed over.
    logic        m_pv [2];
    logic [31:0] m_pa [2];
    logic        m_pw [2];
    logic [2:0]  m_ps [2];
    int          m_owner;        // -1 nobody, 0 I, 1 D
    int          m_passed;
    logic [31:0] m_la;
    logic        m_lw;
    logic [2:0]  m_ls;
    bit          model_on = 1'b0;

    function automatic logic in_req(int x);
        return (x == 0) ? htrans_i[1] : htrans_d[1];
    endfunction
    function automatic logic [31:0] in_addr(int x);
        return (x == 0) ? haddr_i : haddr_d;
    endfunction
    function automatic logic in_write(int x);
        return (x == 0) ? hwrite_i : hwrite_d;
    endfunction
    function automatic logic [2:0] in_size(int x);
        return (x == 0) ? hsize_i : hsize_d;
    endfunction
    function automatic logic rdy(int x);
        if (!rst_n) return 1'b1;
        if (m_owner == x) return hready_m;
        return !m_pv[x];
    endfunction
    function automatic logic wants(int x);
        return m_pv[x] || (rst_n && in_req(x) && rdy(x));
    endfunction
    function automatic int winner();
        if (!rst_n || !hready_m) return -1;
        if (wants(0) && m_passed >= DS) return 0;
        if (wants(1)) return 1;
        if (wants(0)) return 0;
        return -1;
    endfunction

    always @(posedge clk) begin
        int  w;
        logic l0, l1, c0;
        if (!rst_n) begin
            for (int x = 0; x < 2; x++) m_pv[x] = 1'b0;
            m_owner = -1; m_passed = 0; m_la = '0; m_lw = 1'b0; m_ls = '0;
            model_on = 1'b1;
        end else if (model_on) begin
            w  = winner();
            l0 = in_req(0) && rdy(0);
            l1 = in_req(1) && rdy(1);
            c0 = wants(0);
            if (l0 && w != 0) begin
                m_pv[0] = 1'b1; m_pa[0] = haddr_i; m_pw[0] = hwrite_i; m_ps[0] = hsize_i;
            end
            if (l1 && w != 1) begin
                m_pv[1] = 1'b1; m_pa[1] = haddr_d; m_pw[1] = hwrite_d; m_ps[1] = hsize_d;
            end
            if (hready_m) begin
                m_owner = w;
                if (w >= 0) begin
                    m_la = m_pv[w] ? m_pa[w] : in_addr(w);
                    m_lw = m_pv[w] ? m_pw[w] : in_write(w);
                    m_ls = m_pv[w] ? m_ps[w] : in_size(w);
                    m_pv[w] = 1'b0;
                end
                if (w == 0) m_passed = 0;
                else if (w == 1 && c0 && m_passed < DS) m_passed++;
            end
        end
    end

    always @(negedge clk) begin
        int w;
        if (model_on) begin
            w = winner();
            chk("htrans_m", {30'd0, htrans_m}, (w >= 0) ? 32'd2 : 32'd0);
            chk("haddr_m", haddr_m, (w >= 0) ? (m_pv[w] ? m_pa[w] : in_addr(w)) : m_la);
            chk("hwrite_m", {31'd0, hwrite_m}, {31'd0, (w >= 0) ? (m_pv[w] ? m_pw[w] : in_write(w)) : m_lw});
            chk("hsize_m", {29'd0, hsize_m}, {29'd0, (w >= 0) ? (m_pv[w] ? m_ps[w] : in_size(w)) : m_ls});
            chk("hburst_m", {29'd0, hburst_m}, 32'd0);
            chk("hready_i", {31'd0, hready_i}, {31'd0, rdy(0)});
            chk("hready_d", {31'd0, hready_d}, {31'd0, rdy(1)});
            chk("hresp_i", {31'd0, hresp_i}, {31'd0, rst_n && m_owner == 0 && hresp_m});
            chk("hresp_d", {31'd0, hresp_d}, {31'd0, rst_n && m_owner == 1 && hresp_m});
            if (m_owner >= 0) chk("hwdata_m", hwdata_m, (m_owner == 1) ? hwdata_d : hwdata_i);
            if (hready_i) chk("hrdata_i", hrdata_i, hrdata_m);
            if (hready_d) chk("hrdata_d", hrdata_d, hrdata_m);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mst(input logic [1:0] ti, input logic [31:0] ai,
                       input logic [1:0] td, input logic [31:0] ad, input logic wd);
        htrans_i = ti; haddr_i = ai;
        htrans_d = td; haddr_d = ad; hwrite_d = wd;
    endtask

    task automatic slv(input logic r, input logic e, input logic [31:0] d);
        hready_m = r; hresp_m = e; hrdata_m = d;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            nxt();
            mst(2'b00, 32'h0, 2'b00, 32'h8000_0000, 1'b0);
            slv(1'b1, 1'b0, 32'h0);
        end
    endtask

    logic [9:0] exp_d_order;

    initial begin
        exp_d_order = 10'b0111101111;
        hwrite_i = 1'b0; hsize_i = 3'b010; hsize_d = 3'b010;
        hwdata_i = 32'h0; hwdata_d = 32'h0;
        rst_n = 1'b0;
        mst(2'b10, 32'h0000_0040, 2'b10, 32'h8000_0040, 1'b0);
        slv(1'b1, 1'b0, 32'h0);

        // Reset held two cycles while both masters request
        for (int k = 0; k < 2; k++) begin
            nxt();
            chk("rst_htrans_m", {30'd0, htrans_m}, 32'd0);
            chk("rst_hready_i", {31'd0, hready_i}, 32'd1);
            chk("rst_hready_d", {31'd0, hready_d}, 32'd1);
            chk("rst_hresp", {30'd0, hresp_i, hresp_d}, 32'd0);
        end
        chk("rst_haddr_m", haddr_m, 32'd0);
        rst_n = 1'b1;
        mst(2'b00, 32'h0, 2'b00, 32'h8000_0000, 1'b0);

        // Lone I read, then a SEQ beat that must go out as NONSEQ
        nxt();
        mst(2'b10, 32'h0000_0100, 2'b00, 32'h8000_0000, 1'b0);
        #1;
        chk("lone_htrans", {30'd0, htrans_m}, 32'd2);
        chk("lone_haddr", haddr_m, 32'h0000_0100);
        nxt();
        mst(2'b11, 32'h0000_0104, 2'b00, 32'h8000_0000, 1'b0);
        slv(1'b1, 1'b0, 32'h1234_5678);
        #1;
        chk("lone_hrdata_i", hrdata_i, 32'h1234_5678);
        chk("lone_hready_i", {31'd0, hready_i}, 32'd1);
        chk("seq_as_nonseq", {30'd0, htrans_m}, 32'd2);
        chk("seq_haddr", haddr_m, 32'h0000_0104);
        idle(2);

        // Simultaneous: D write wins, I read follows in the next slot
        nxt();
        mst(2'b10, 32'h0000_0200, 2'b10, 32'h8000_0000, 1'b1);
        #1;
        chk("sim_c0_haddr", haddr_m, 32'h8000_0000);
        chk("sim_c0_hwrite", {31'd0, hwrite_m}, 32'd1);
        nxt();
        mst(2'b00, 32'h0, 2'b00, 32'h8000_0000, 1'b0);
        hwdata_d = 32'hDEAD_BEEF;
        #1;
        chk("sim_c1_haddr", haddr_m, 32'h0000_0200);
        chk("sim_c1_htrans", {30'd0, htrans_m}, 32'd2);
        chk("sim_c1_hwdata", hwdata_m, 32'hDEAD_BEEF);
        chk("sim_c1_hready_d", {31'd0, hready_d}, 32'd1);
        chk("sim_c1_hready_i", {31'd0, hready_i}, 32'd0);
        nxt();
        slv(1'b1, 1'b0, 32'hCAFE_0200);
        #1;
        chk("sim_c2_hready_i", {31'd0, hready_i}, 32'd1);
        chk("sim_c2_hrdata_i", hrdata_i, 32'hCAFE_0200);
        idle(2);

        // D read with two wait states; I arrives during them and waits
        nxt();
        mst(2'b00, 32'h0, 2'b10, 32'h8000_0010, 1'b0);
        #1;
        chk("ws_c0_haddr", haddr_m, 32'h8000_0010);
        nxt();
        mst(2'b10, 32'h0000_0300, 2'b00, 32'h8000_0000, 1'b0);
        slv(1'b0, 1'b0, 32'h0);
        #1;
        chk("ws_c1_hready_d", {31'd0, hready_d}, 32'd0);
        chk("ws_c1_htrans", {30'd0, htrans_m}, 32'd0);
        chk("ws_c1_haddr", haddr_m, 32'h8000_0010);
        nxt();
        mst(2'b00, 32'h0, 2'b00, 32'h8000_0000, 1'b0);
        #1;
        chk("ws_c2_hready_d", {31'd0, hready_d}, 32'd0);
        chk("ws_c2_hready_i", {31'd0, hready_i}, 32'd0);
        chk("ws_c2_htrans", {30'd0, htrans_m}, 32'd0);
        chk("ws_c2_haddr", haddr_m, 32'h8000_0010);
        nxt();
        slv(1'b1, 1'b0, 32'hD0D0_D0D0);
        #1;
        chk("ws_c3_hready_d", {31'd0, hready_d}, 32'd1);
        chk("ws_c3_hrdata_d", hrdata_d, 32'hD0D0_D0D0);
        chk("ws_c3_htrans", {30'd0, htrans_m}, 32'd2);
        chk("ws_c3_haddr", haddr_m, 32'h0000_0300);
        nxt();
        #1;
        chk("ws_c4_hready_i", {31'd0, hready_i}, 32'd1);
        idle(2);

        // Starvation bound: both request every cycle
        for (int k = 0; k < 10; k++) begin
            nxt();
            mst(2'b10, 32'h0000_0400, 2'b10, 32'h8000_0400, 1'b0);
            slv(1'b1, 1'b0, 32'h0);
            #1;
            chk("starve_htrans", {30'd0, htrans_m}, 32'd2);
            chk("starve_grant_is_d", {31'd0, haddr_m[31]}, {31'd0, exp_d_order[k]});
        end
        idle(3);

        // ERROR on a D read while I is parked
        nxt();
        mst(2'b10, 32'h0000_0500, 2'b10, 32'h8000_0020, 1'b0);
        #1;
        chk("err_c0_haddr", haddr_m, 32'h8000_0020);
        nxt();
        mst(2'b00, 32'h0, 2'b00, 32'h8000_0000, 1'b0);
        slv(1'b0, 1'b1, 32'h0);
        #1;
        chk("err_c1_hresp_d", {31'd0, hresp_d}, 32'd1);
        chk("err_c1_hready_d", {31'd0, hready_d}, 32'd0);
        chk("err_c1_hresp_i", {31'd0, hresp_i}, 32'd0);
        chk("err_c1_htrans", {30'd0, htrans_m}, 32'd0);
        nxt();
        slv(1'b1, 1'b1, 32'h0);
        #1;
        chk("err_c2_hresp_d", {31'd0, hresp_d}, 32'd1);
        chk("err_c2_hready_d", {31'd0, hready_d}, 32'd1);
        chk("err_c2_hresp_i", {31'd0, hresp_i}, 32'd0);
        chk("err_c2_haddr", haddr_m, 32'h0000_0500);
        chk("err_c2_htrans", {30'd0, htrans_m}, 32'd2);
        nxt();
        slv(1'b1, 1'b0, 32'h5555_0500);
        #1;
        chk("err_c3_hready_i", {31'd0, hready_i}, 32'd1);
        chk("err_c3_hrdata_i", hrdata_i, 32'h5555_0500);
        idle(2);

        // Reset in the middle of a stalled transfer abandons everything
        nxt();
        mst(2'b00, 32'h0, 2'b10, 32'h8000_0030, 1'b1);
        nxt();
        mst(2'b10, 32'h0000_0600, 2'b00, 32'h8000_0000, 1'b0);
        slv(1'b0, 1'b0, 32'h0);
        nxt();
        mst(2'b00, 32'h0, 2'b00, 32'h8000_0000, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_htrans", {30'd0, htrans_m}, 32'd0);
        chk("mrst_hready", {30'd0, hready_i, hready_d}, 32'd3);
        nxt();
        rst_n = 1'b1;
        slv(1'b1, 1'b0, 32'h0);
        #1;
        chk("post_rst_htrans", {30'd0, htrans_m}, 32'd0);
        chk("post_rst_haddr", haddr_m, 32'd0);
        chk("post_rst_hready", {30'd0, hready_i, hready_d}, 32'd3);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ahb_id_arbiter.md
# ahb_id_arbiter

Two-master to one-slave AHB-Lite arbiter that lets the CPU's instruction port (`*_I`) and data port (`*_D`) share a single AHB-Lite master port (`*_M`) toward a unified memory/interconnect. Data has fixed priority, with a bounded-starvation rule for instruction fetch. Each master's accepted-but-not-yet-issued transfer is buffered, so both masters see ordinary AHB-Lite wait states and no added latency when uncontested. The block sits between the CPU top level and the single-port memory/peripheral fabric.

## Interface
- `D_STREAK`, default 4: maximum consecutive D grants while I is waiting before I is granted once (≥1).
- `HCLK` in 1: clock, all state updates on rising edge.
- `HRESETn` in 1: reset, synchronous, active-low.
- `HADDR_I`/`HADDR_D` in 32: master address.
- `HTRANS_I`/`HTRANS_D` in 2: master transfer type.
- `HWRITE_I`/`HWRITE_D` in 1: master write flag (I side tied 0 by the CPU).
- `HSIZE_I`/`HSIZE_D` in 3: master size.
- `HWDATA_I`/`HWDATA_D` in 32: master write data, data phase.
- `HRDATA_I`/`HRDATA_D` out 32: read data to master.
- `HREADY_I`/`HREADY_D` out 1: ready to master.
- `HRESP_I`/`HRESP_D` out 1: response to master.
- `HADDR_M` out 32, `HTRANS_M` out 2, `HWRITE_M` out 1, `HSIZE_M` out 3, `HBURST_M` out 3 (constant 3'b000 SINGLE), `HWDATA_M` out 32: downstream master signals.
- `HRDATA_M` in 32, `HREADY_M` in 1, `HRESP_M` in 1: downstream slave response.

## Operation
- **Accept.** Master x's transfer is accepted at an edge where `HTRANS_x[1]`=1 and `HREADY_x`=1. It is then *outstanding* until its downstream data phase completes.
- **Per-master state:**
  - `pend_x`: valid, addr, write, size. Holds an accepted transfer not yet issued.
  - `dp_owner` ∈ {NONE, I, D}, plus `dp_write`: the owner of the current downstream data phase.
- **Address slot.** The slot is free in any cycle where `HREADY_M`=1.
- **Candidates per master:** `pend_x` if valid, else a live request (`HTRANS_x[1]` && `HREADY_x`).
- **Selection.** D beats I, except when `streak`==`D_STREAK` and I has a candidate; then I wins.
- **Winner.** Drives `HADDR_M`/`HWRITE_M`/`HSIZE_M` combinationally from its pend register or from its live inputs. `HTRANS_M`=NONSEQ (SEQ from a master is reissued as NONSEQ).
- **No candidate, or slot not free:** `HTRANS_M`=IDLE and `HADDR_M` holds its last value.
- **Losing live request** is captured into `pend_x` at the edge.
- **At an edge with `HREADY_M`=1:**
  - `dp_owner` ← winner (or NONE).
  - `dp_write` ← winner's write.
  - Winner's `pend` is cleared.
- **`streak`:**
  - +1 (saturating at `D_STREAK`) when D wins while I has a candidate.
  - 0 when I wins.
  - Unchanged otherwise.
- **`HREADY_x`** = !outstanding_x || (`dp_owner`==x && `HREADY_M`).
- **`HRESP_x`** = (`dp_owner`==x) ? `HRESP_M` : 0.
- **`HRDATA_x`** = `HRDATA_M` (pass-through, qualified by `HREADY_x`).
- **`HWDATA_M`** = `HWDATA_D` if `dp_owner`==D, else `HWDATA_I`. Data is valid because the master holds its data-phase write data while its `HREADY` is low.
- **ERROR responses.** The two-cycle AHB ERROR (cycle 1 `HREADY_M`=0/`HRESP_M`=1, cycle 2 1/1) is forwarded to the owner only. The other master's pend is untouched and is issued afterwards.
- **One outstanding per master:** a master cannot issue again while its `HREADY_x`=0.

## Timing
- **Reset** (`HRESETn` low at an edge):
  - `pend_I`/`pend_D` invalid, `dp_owner`=NONE, `streak`=0.
  - Outputs: `HTRANS_M`=IDLE, `HADDR_M`=0, `HWRITE_M`=0, `HSIZE_M`=0, `HREADY_I`=`HREADY_D`=1, `HRESP_I`=`HRESP_D`=0.
  - Reset mid-transfer abandons all state with no completion; the downstream slave shares `HRESETn`.
- **Latency:**
  - Uncontested: zero added cycles; downstream address phase in the same cycle as the master's.
  - Losing master: +1 slot per preceding transfer.
- **Wait states.** While `HREADY_M`=0, the address on `*_M` is held stable and no pend is issued.
- **Simultaneous fresh requests, slot free:** D issued, I captured; I issued in the next free slot unless a new D request wins (streak < `D_STREAK`).
- **Worst-case I wait:** `D_STREAK`+1 slots.

## Test plan
- **Reset.** Hold `HRESETn`=0 for 2 cycles with both masters driving NONSEQ → `HTRANS_M`=00, `HREADY_I`=`HREADY_D`=1, `HRESP_*`=0, no transfer issued.
- **Lone I read.** I read 0x0000_0100, zero-wait slave returns 0x1234_5678 → `HADDR_M`=0x100 NONSEQ in the same cycle; next cycle `HRDATA_I`=0x1234_5678, `HREADY_I`=1.
- **Simultaneous requests.** I read 0x200 and D write 0x8000_0000 (data 0xDEADBEEF) in cycle 0:
  - cycle 0: `HADDR_M`=0x8000_0000.
  - cycle 1: `HADDR_M`=0x200, `HWDATA_M`=0xDEADBEEF, `HREADY_D`=1, `HREADY_I`=0.
  - cycle 2: `HREADY_I`=1 with read data.
- **Wait states.** D read, slave inserts 2 wait states, I pending → `HREADY_D`=0 for 2 cycles, I address not issued until the cycle `HREADY_M`=1, `HADDR_M` stable throughout.
- **Starvation bound.** `D_STREAK`=4, D and I requesting every cycle → downstream grant order D,D,D,D,I,D,D,D,D,I.
- **Error response.** Slave returns ERROR on a D read while I is pending → `HRESP_D`=1 for both cycles, `HREADY_D` 0 then 1, `HRESP_I`=0; I transfer issued in the slot after the error completes.
